// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-and-add unsigned multiplier.
// One partial product is folded in per clock using a ripple-carry adder
// built from full_adder cells; the result appears WIDTH+1 edges after start.
//
// Handshake: start is accepted only when the block is idle (busy=0).
// While busy=1, start is ignored and nothing is queued. done is a
// single-cycle pulse; product is valid in that cycle and holds its value
// until the next operation completes. There is no backpressure.

// Single-bit full adder cell used to build the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module shift_add_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]   m_q;
  logic [WIDTH:0]     acc_q;
  logic [WIDTH-1:0]   q_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] p_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH:0]     carry;
  logic [2*WIDTH-1:0] shifted;
  logic               last_step;

  // The carry bit of ACC is always shifted down before it is ever used as an
  // adder input, so its stored copy is never read back.
  logic unused_acc_msb;
  assign unused_acc_msb = acc_q[WIDTH];

  // Add the multiplicand only when the current multiplier bit is set; a zero
  // addend yields carry-out 0, matching the no-add case.
  assign addend   = q_q[0] ? m_q : '0;
  assign carry[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rca
      full_adder u_fa (
        .a    (acc_q[gi]),
        .b    (addend[gi]),
        .cin  (carry[gi]),
        .s    (sum[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  // {c, sum, Q} shifted right by one, Q's LSB dropped: new {ACC[W-1:0], Q}.
  assign shifted   = {carry[WIDTH], sum, q_q[WIDTH-1:1]};
  assign last_step = (cnt_q == CW'(WIDTH - 1));

  // Next-state decode for the IDLE/RUN/DONE controller.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus registered busy/done flags derived from next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE);
    end
  end

  // Datapath: operand load on accept, one shift-add step per RUN cycle,
  // product captured only on the final step so aborted runs never leak out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q   <= '0;
      acc_q <= '0;
      q_q   <= '0;
      cnt_q <= '0;
      p_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_q   <= a;
            q_q   <= b;
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          acc_q <= {1'b0, shifted[2*WIDTH-1:WIDTH]};
          q_q   <= shifted[WIDTH-1:0];
          cnt_q <= cnt_q + CW'(1);
          if (last_step) p_q <= shifted;
        end
        default: ;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = p_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl at WIDTH=4.
// Driver tasks issue operations and push the hand-computed product and the
// cycle in which done must appear; a monitor on the falling edge pops and
// compares whenever done is high, and checks that product holds otherwise.
module tb_shift_add_mult_ctrl;
  localparam int W  = 4;
  localparam int PW = 2 * W;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  shift_add_mult_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit rst_at_edge = 1'b1;
  always @(posedge clk) rst_at_edge <= !rst_n;

  // Scoreboard
  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] exp_q[$];
  int            exp_t[$];
  logic [PW-1:0] held = '0;
  bit            mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare on every done pulse, verify product holds otherwise.
  always @(negedge clk) begin
    if (mon_en) begin : mon
      logic [PW-1:0] e;
      int            t;
      if (rst_at_edge) held = '0;
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 required done=0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          t = exp_t.pop_front();
          check("product", 32'(product), 32'(e));
          check("latency", 32'(cyc), 32'(t));
          held = e;
        end
      end else begin
        check("product_hold", 32'(product), 32'(held));
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy=%b required 0 within 50 cycles", busy);
    end
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input bit expect_ok);
    logic [PW-1:0] pr;
    pr    = PW'(av) * PW'(bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    if (expect_ok) begin
      exp_q.push_back(pr);
      exp_t.push_back(cyc + W + 1);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    wait_idle();
    issue(av, bv, 1'b1);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    mon_en = 1'b1;

    // Release reset in the same cycle start is raised: 3*5 = 15.
    rst_n = 1'b1;
    issue(4'd3, 4'd5, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check("busy_cycles", 32'(n), 32'd5);

    // Corner operands.
    run_op(4'd15, 4'd15);
    run_op(4'd0, 4'd9);
    run_op(4'd9, 4'd0);

    // start and operand changes while busy must be ignored.
    wait_idle();
    issue(4'd3, 4'd5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      a     = W'(7 + i);
      b     = W'(7 + 2 * i);
      tick();
    end
    start = 1'b0;

    // Reset in the second RUN cycle of 6*7 aborts it.
    wait_idle();
    issue(4'd6, 4'd7, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    rst_n = 1'b1;
    repeat (8) tick();
    run_op(4'd6, 4'd7);

    // Back-to-back: second start in the first idle cycle after done.
    run_op(4'd2, 4'd3);
    wait_idle();
    issue(4'd4, 4'd4, 1'b1);

    // Every operand pair.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        run_op(W'(ai), W'(bi));
      end
    end

    // Drain outstanding expectations.
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending results required 0", exp_q.size());
    end
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_mult_ctrl.md
SHIFT_ADD_MULT_CTRL -- requirements
Module: shift_add_mult_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, operand width in bits; legal range 2..8.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  request to begin one multiplication; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  unsigned multiplicand; sampled on the edge that accepts start.
REQ-006 Port: b  input  WIDTH  unsigned multiplier; sampled on the edge that accepts start.
REQ-007 Port: busy  output  1  high while an operation is in progress (RUN or DONE state).
REQ-008 Port: done  output  1  one-cycle pulse; product valid and final.
REQ-009 Port: product  output  2*WIDTH  unsigned result a*b; held until the next operation completes.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-011 The datapath SHALL perform each partial-sum addition with a WIDTH-bit ripple-carry adder built from full_adder instances, carry-in 0, with the carry-out retained as bit WIDTH.
REQ-012 Registers: multiplicand M (WIDTH), accumulator high half ACC (WIDTH+1 incl. carry), low half Q (WIDTH), step counter CNT (ceil(log2(WIDTH+1)) bits), product register P (2*WIDTH).
REQ-013 IDLE: when start=1, the edge SHALL load M<=a, Q<=b, ACC<=0, CNT<=0, and move to RUN; when start=0, the state is held.
REQ-014 RUN, each edge: if Q[0]=1, sum = ACC[WIDTH-1:0] + M with carry c, otherwise sum = ACC[WIDTH-1:0] and c = 0; then {ACC,Q} <= {c, sum, Q} shifted right by one (the LSB of Q is dropped); CNT <= CNT+1.
REQ-015 RUN SHALL execute exactly WIDTH steps; the edge performing step WIDTH SHALL load P with the final {ACC[WIDTH-1:0],Q} and move to DONE.
REQ-016 DONE: done=1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-017 Latency: when start is sampled at edge E0, done SHALL be high in the cycle following edge E0+WIDTH (WIDTH+1 edges total), independent of operand values.
REQ-018 busy SHALL be high in RUN and DONE and low in IDLE; busy and done SHALL be registered outputs with no combinational path from the inputs.
REQ-019 start asserted while busy=1 (including in DONE) SHALL be ignored, with no queuing; a and b changes during RUN SHALL NOT affect the result.
REQ-020 Back-to-back: start high in the IDLE cycle immediately after DONE SHALL be accepted, giving a minimum period of WIDTH+2 cycles per operation.
REQ-021 P SHALL change only at the step-WIDTH edge of RUN; between operations product SHALL hold the last result.
REQ-022 Boundary values: a=0 or b=0 SHALL yield 0; a=b=2^WIDTH-1 SHALL yield (2^WIDTH-1)^2 with no overflow, since the product is 2*WIDTH bits wide.

Reset
REQ-023 On a rising edge with rst_n=0: state<=IDLE; busy=0; done=0; product=0; M, ACC, Q, CNT <= 0.
REQ-024 Reset SHALL take priority over start and over every state transition, including when asserted mid-RUN or in DONE; an aborted operation SHALL NOT produce done or update product.
REQ-025 rst_n deasserting in the same cycle as start=1 SHALL allow start to be accepted on the first edge with rst_n=1.

Verification
REQ-026 WIDTH=4, reset, then a=3, b=5 with start pulsed one cycle -> busy high for 5 cycles, done pulses in the 5th cycle after the start edge, product=15.
REQ-027 a=15, b=15 -> product=225; then a=0, b=9 -> product=0; then a=9, b=0 -> product=0.
REQ-028 During RUN of 3*5, assert start with a=7, b=7 and change a, b every cycle -> product=15, only one done pulse.
REQ-029 rst_n=0 on the 2nd RUN cycle of 6*7 -> next cycle busy=0, done=0, product=0; no done pulse follows; a fresh 6*7 then gives product=42.
REQ-030 Back-to-back: 2*3, then start in the first IDLE cycle after DONE with 4*4 -> done pulses 6 cycles apart, products 6 then 16.
REQ-031 Exhaustive: all 256 operand pairs at WIDTH=4 compared against the reference a*b; fixed latency of 5 cycles checked for each pair.
